// File: rtl/reversible_serial_adder.sv
// Bit-serial WIDTH-bit adder. One reversible full-adder cell handles one
// operand bit pair per clock, LSB first. A registered carry closes the loop,
// and the sum bits collect in a shift register. The result is published on
// the edge that enters DONE.

// Single-bit full adder built from two cascaded Peres gates.
// The garbage lines are brought out on out_vec.
module reversible_full_adder (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       sum,
  output logic       cout,
  output logic [3:0] out_vec
);

  logic w_p1_q;
  logic w_p1_r;

  // First Peres gate (a, b, 0): q = a^b, r = a&b
  assign w_p1_q  = a ^ b;
  assign w_p1_r  = a & b;

  // Second Peres gate (a^b, cin, a&b): q = sum, r = carry
  assign sum     = w_p1_q ^ cin;
  assign cout    = (w_p1_q & cin) ^ w_p1_r;

  // Garbage lines: preserved inputs and the intermediate propagate term
  assign out_vec = {a, w_p1_q, b, cin};

endmodule

module reversible_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic             w_cell_sum;
  logic             w_cell_cout;
  logic [3:0]       w_unused_garbage;
  logic [WIDTH-1:0] w_sum_shifted;

  // The cell sees the current LSBs and the registered carry.
  // This is the only combinational path in the carry loop.
  reversible_full_adder u_cell (
    .a       (r_a_sh[0]),
    .b       (r_b_sh[0]),
    .cin     (r_carry),
    .sum     (w_cell_sum),
    .cout    (w_cell_cout),
    .out_vec (w_unused_garbage)
  );

  assign w_load        = (r_state == S_IDLE) && start;
  assign w_run         = (r_state == S_RUN);
  assign w_last        = w_run && (r_cnt == LAST);
  assign w_sum_shifted = {w_cell_sum, r_sum_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE, and DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, and publish
  // the completed shift value on the last RUN edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_shifted;
      r_carry  <= w_cell_cout;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_sum_shifted;
        r_cout <= w_cell_cout;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_reversible_serial_adder.sv
// Bench for reversible_serial_adder: directed and random 8-bit operations,
// handshake timing, ignored start, back-to-back, mid-run reset, and an
// exhaustive 4-bit sweep. The reference result is plain integer addition.
module tb_reversible_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reversible_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  reversible_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit operation with latency, busy-length and result checks
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] exp;
    int         busy_cnt;
    int         n;
    bit         seen;
    exp = {1'b0, x} + {1'b0, y} + {8'd0, c};
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8   = 1'b0;
    busy_cnt = busy8 ? 1 : 0;
    seen     = 0;
    n        = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done8) seen = 1;
      else if (busy8) busy_cnt++;
    end
    chk("op8_done_seen", {31'd0, seen}, 32'd1);
    chk("op8_latency", n, 8);
    chk("op8_busy_cycles", busy_cnt, 8);
    chk("op8_busy_low_at_done", {31'd0, busy8}, 32'd0);
    chk("op8_result", {23'd0, cout8, sum8}, {23'd0, exp});
    @(posedge clk); #1;
    chk("op8_done_pulse_one_cycle", {31'd0, done8}, 32'd0);
  endtask

  // One 4-bit operation checked at its done pulse
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] exp;
    int         n;
    bit         seen;
    exp = {1'b0, x} + {1'b0, y} + {4'd0, c};
    @(negedge clk);
    a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    seen   = 0;
    n      = 0;
    while (!seen && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (done4) seen = 1;
    end
    if (!seen) chk("op4_timeout", {31'd0, seen}, 32'd1);
    chk($sformatf("op4_%0h_%0h_%0h", c, x, y), {27'd0, cout4, sum4}, {27'd0, exp});
    @(posedge clk); #1;
  endtask

  logic [7:0] bb_a [4];
  logic [7:0] bb_b [4];
  logic       bb_c [4];
  logic [8:0] bb_exp [4];
  logic [8:0] prev;
  logic [8:0] got;
  int         dones;
  int         idx;
  int         last_done;
  int         n;

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed and boundary operations
    op8(8'h3C, 8'h5A, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h00, 8'h00, 1'b0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Operand change and start pulse during RUN are ignored
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    dones = 0;
    got   = '0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 2) start8 = 1'b1;
      if (i == 5) start8 = 1'b0;
      if (done8) begin
        dones++;
        got = {cout8, sum8};
      end
    end
    chk("ign_done_count", dones, 1);
    chk("ign_result", {23'd0, got}, 32'h033);

    // Reset after four RUN cycles
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    chk("midrst_sum", {24'd0, sum8}, 32'd0);
    chk("midrst_cout", {31'd0, cout8}, 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    chk("midrst_no_done", dones, 0);
    op8(8'h7F, 8'h01, 1'b0);

    // Back-to-back with start held high
    for (int i = 0; i < 4; i++) begin
      bb_a[i]   = 8'($urandom);
      bb_b[i]   = 8'($urandom);
      bb_c[i]   = 1'($urandom);
      bb_exp[i] = {1'b0, bb_a[i]} + {1'b0, bb_b[i]} + {8'd0, bb_c[i]};
    end
    prev = 9'h080;
    @(negedge clk);
    a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0]; start8 = 1'b1;
    idx = 0;
    last_done = 0;
    n = 0;
    while (idx < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done8) begin
        chk($sformatf("b2b_result_%0d", idx), {23'd0, cout8, sum8}, {23'd0, bb_exp[idx]});
        if (idx > 0) chk("b2b_interval", cyc - last_done, 10);
        last_done = cyc;
        prev = bb_exp[idx];
        idx++;
        if (idx < 4) begin
          a8 = bb_a[idx]; b8 = bb_b[idx]; cin8 = bb_c[idx];
        end else begin
          start8 = 1'b0;
        end
      end else if (busy8) begin
        chk("b2b_sum_hold", {23'd0, cout8, sum8}, {23'd0, prev});
      end
    end
    chk("b2b_all_done", idx, 4);
    start8 = 1'b0;
    repeat (2) @(posedge clk);

    // Exhaustive 4-bit sweep
    for (int i = 0; i < 512; i++) begin
      op4(i[3:0], i[7:4], i[8]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
